// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state debounce FSM and
// registered press/release/long-press strobes. Long press gated by KEY_LONG_PRESS_EN.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  // Synchronizer (reset to the released level, key_in is active-low)
  logic sync1_d, sync1_q;
  logic key_sync_d, key_sync_q;

  always_comb begin
    sync1_d    = key_in;
    key_sync_d = sync1_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q    <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      key_sync_q <= key_sync_d;
    end
  end

  // Debounce FSM
  state_t          state_d, state_q;
  logic [DB_W-1:0] db_cnt_d, db_cnt_q;
  logic            key_state_d, key_state_q;
  logic            press_d, press_q;
  logic            release_d, release_q;
  logic            new_press;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    new_press   = 1'b0;
    case (state_q)
      IDLE: begin
        db_cnt_d = '0;
        if (!key_sync_q) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (key_sync_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          db_cnt_d    = '0;
          press_d     = 1'b1;
          key_state_d = 1'b1;
          new_press   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        db_cnt_d = '0;
        if (key_sync_q) state_d = REL_DB;
      end
      REL_DB: begin
        if (!key_sync_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          db_cnt_d    = '0;
          release_d   = 1'b1;
          key_state_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign key_state     = key_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LG_W = $clog2(LONG_CYCLES);
  localparam logic [LG_W-1:0] LONG_LAST = LG_W'(LONG_CYCLES - 1);

  logic [LG_W-1:0] long_cnt_d, long_cnt_q;
  logic            fired_d, fired_q;
  logic            long_d, long_q;

  // Counter only advances while settled in PRESSED, so REL_DB time is held out.
  always_comb begin
    long_cnt_d = long_cnt_q;
    fired_d    = fired_q;
    long_d     = 1'b0;
    if (new_press) begin
      long_cnt_d = '0;
      fired_d    = 1'b0;
    end else if (state_q == PRESSED) begin
      if (long_cnt_q != LONG_LAST) begin
        long_cnt_d = long_cnt_q + LG_W'(1);
      end else if (!fired_q) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      long_cnt_q <= '0;
      fired_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      fired_q    <= fired_d;
      long_q     <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYCLES != 0);
  assign long_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;
  localparam int unsigned D = 4;
  localparam int unsigned L = 16;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_state, press_pulse, release_pulse, long_pulse;

  key_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted level flips after D+1 consecutive opposite
  // samples of the 2-cycle-delayed key; long fires after L settled-held edges.
  bit [1:0] m_dly;
  bit       m_acc, m_press, m_rel, m_long, m_fired;
  int       m_run, m_held;

  function automatic void model_reset();
    m_dly = 2'b11; m_acc = 0; m_press = 0; m_rel = 0; m_long = 0;
    m_fired = 0; m_run = 0; m_held = 0;
  endfunction

  function automatic void model_step();
    bit lvl;
    if (sys_rst) begin model_reset(); return; end
    m_press = 0; m_rel = 0; m_long = 0;
    lvl = !m_dly[1];
    if (m_acc && m_run == 0) begin
      m_held++;
      if (m_held == L && !m_fired) begin m_fired = 1; m_long = LONG_EN; end
    end
    if (lvl != m_acc) begin
      m_run++;
      if (m_run == D + 1) begin
        m_acc = lvl; m_run = 0;
        if (lvl) begin m_press = 1; m_held = 0; m_fired = 0; end
        else m_rel = 1;
      end
    end else begin
      m_run = 0;
    end
    m_dly[1] = m_dly[0];
    m_dly[0] = key_in;
  endfunction

  function automatic logic [3:0] obs();
    return {key_state, press_pulse, release_pulse, long_pulse};
  endfunction

  function automatic logic [3:0] expv();
    return {m_acc, m_press, m_rel, m_long};
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    key_in = 1'b1;
    repeat (3 * D + 6) cyc();
  endtask

  task automatic test_reset();
    int p = -1;
    sys_rst = 1'b1; key_in = 1'b0; model_reset();
    repeat (3) begin
      cyc();
      total++;
      if (obs() !== 4'b0000) begin bad++; $display("FAIL reset_hold got=%b want=0000", obs()); end
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL reset_follow i=%0d got=%b want=%b", i, obs(), expv()); end
      if (press_pulse && p < 0) p = i;
    end
    total++;
    if (p !== int'(D + 2)) begin bad++; $display("FAIL reset_press_latency got=%0d want=%0d", p, D + 2); end
    settle();
  endtask

  task automatic test_clean();
    int p = -1, r = -1, np = 0, nr = 0;
    key_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) key_in = 1'b1;
      cyc();
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL clean_cycle i=%0d got=%b want=%b", i, obs(), expv()); end
      if (press_pulse) begin np++; if (p < 0) p = i; end
      if (release_pulse) begin nr++; if (r < 0) r = i; end
      key_in = (i >= 9);
    end
    total++;
    if (p !== int'(D + 2) || np !== 1) begin bad++; $display("FAIL clean_press got=%0d/%0d want=%0d/1", p, np, D + 2); end
    total++;
    if (r !== int'(10 + D + 2) || nr !== 1) begin bad++; $display("FAIL clean_release got=%0d/%0d want=%0d/1", r, nr, 10 + D + 2); end
    settle();
  endtask

  task automatic test_bounce();
    int i = 0, p = -1, np = 0, last_fall = 0;
    for (int b = 0; b < 6; b++) begin
      last_fall = i;
      for (int k = 0; k < ((b == 5) ? 20 : 5); k++) begin
        key_in = (b < 5 && k >= 3);
        cyc();
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL bounce_cycle i=%0d got=%b want=%b", i, obs(), expv()); end
        if (press_pulse) begin np++; if (p < 0) p = i; end
        i++;
      end
    end
    total++;
    if (np !== 1 || p !== last_fall + int'(D) + 2) begin
      bad++; $display("FAIL bounce_press got=%0d@%0d want=1@%0d", np, p, last_fall + D + 2);
    end
    settle();
  endtask

  task automatic test_long();
    int p = -1, l = -1, nl = 0, lat;
    key_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL long_cycle i=%0d got=%b want=%b", i, obs(), expv()); end
      if (press_pulse && p < 0) p = i;
      if (long_pulse) begin nl++; if (l < 0) l = i; end
    end
    lat = (l < 0 || p < 0) ? -1 : l - p;
    total++;
    if (lat !== (LONG_EN ? int'(L) : -1) || nl !== int'(LONG_EN)) begin
      bad++; $display("FAIL long_latency got=%0d n=%0d want=%0d n=%0d", lat, nl, LONG_EN ? int'(L) : -1, LONG_EN);
    end
    settle();
  endtask

  task automatic test_glitch_held();
    int p = -1, l = -1, nr = 0, lat, gl = -1;
    key_in = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL glitch_cycle i=%0d got=%b want=%b", i, obs(), expv()); end
      if (press_pulse && p < 0) begin p = i; gl = i; end
      if (long_pulse && l < 0) l = i;
      if (release_pulse) nr++;
      key_in = (gl >= 0 && (i == gl || i == gl + 1));
    end
    lat = (l < 0 || p < 0) ? -1 : l - p;
    total++;
    if (nr !== 0 || key_state !== 1'b1) begin bad++; $display("FAIL glitch_release got=%0d/%b want=0/1", nr, key_state); end
    total++;
    if (lat !== (LONG_EN ? int'(L) + 2 : -1)) begin
      bad++; $display("FAIL glitch_long got=%0d want=%0d", lat, LONG_EN ? int'(L) + 2 : -1);
    end
    settle();
  endtask

  task automatic test_mid_reset();
    int p = -1, early = 0;
    key_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL midrst_pre i=%0d got=%b want=%b", i, obs(), expv()); end
      if (press_pulse) early++;
    end
    #2 sys_rst = 1'b1; model_reset();
    #1;
    total++;
    if (obs() !== 4'b0000) begin bad++; $display("FAIL midrst_async got=%b want=0000", obs()); end
    repeat (2) cyc();
    sys_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL midrst_post i=%0d got=%b want=%b", i, obs(), expv()); end
      if (press_pulse && p < 0) p = i;
    end
    total++;
    if (early !== 0 || p !== int'(D + 2)) begin bad++; $display("FAIL midrst_press got=%0d early=%0d want=%0d early=0", p, early, D + 2); end
    settle();
  endtask

  task automatic test_random();
    bit lvl = 1'b0;
    int np = 0, nr = 0, mp = 0, mr = 0;
    for (int run = 0; run < 150; run++) begin
      int len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        key_in = lvl;
        cyc();
        total++;
        if (obs() !== expv() || (press_pulse && release_pulse) || (press_pulse && long_pulse)) begin
          bad++; $display("FAIL random_cycle run=%0d got=%b want=%b", run, obs(), expv());
        end
        np += press_pulse; nr += release_pulse; mp += m_press; mr += m_rel;
      end
      lvl = !lvl;
    end
    total++;
    if (np !== mp || nr !== mr) begin bad++; $display("FAIL random_counts got=%0d/%0d want=%0d/%0d", np, nr, mp, mr); end
    settle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_bounce();
    test_long();
    test_glitch_held();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
